// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Writable instruction memory filled from a little-endian byte stream
//            (word count, then words); combinational fetch port for the core.
//            Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module imem_loader #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic [31:0] addr,
   output logic [31:0] data_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int DEPTH = 2**ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {S_LEN = 2'd0, S_DATA = 2'd1, S_CSUM = 2'd2, S_DONE = 2'd3} state_t;
   localparam state_t S_END = S_CSUM;
`else
   typedef enum logic [1:0] {S_LEN = 2'd0, S_DATA = 2'd1, S_DONE = 2'd3} state_t;
   localparam state_t S_END = S_DONE;
`endif

   state_t       r_state;
   state_t       w_state_nxt;
   logic [1:0]   r_bcnt;
   logic [31:0]  r_len;
   logic [31:0]  r_widx;
   logic [23:0]  r_bytes;
   logic         r_busy;
   logic         r_done;
   logic         r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]   r_csum;
`endif

   logic [31:0]  r_mem [0:DEPTH-1];

   logic         w_fire;
   logic         w_byte_last;
   logic         w_ovf;
   logic         w_we;
   logic         w_err_set;
   logic [31:0]  w_len_full;
   logic [31:0]  w_word;
   logic         w_unused_addr;

   assign in_ready    = (r_state != S_DONE);
   assign w_fire      = in_valid && in_ready;
   assign w_byte_last = (r_bcnt == 2'd3);
   assign w_len_full  = {in_data, r_len[31:8]};
   assign w_word      = {in_data, r_bytes};
   // widx keeps counting past the array so overflowing words never alias low memory
   assign w_ovf       = |r_widx[31:ADDR_WIDTH];

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         S_LEN: begin
            if (w_fire && w_byte_last) begin
               w_state_nxt = (w_len_full != 32'd0) ? S_DATA : S_END;
            end
         end
         S_DATA: begin
            if (w_fire && w_byte_last) begin
               w_we      = !w_ovf;
               w_err_set = w_ovf;
               if (r_widx + 32'd1 == r_len) begin
                  w_state_nxt = S_END;
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (w_fire) begin
               w_state_nxt = S_DONE;
               w_err_set   = (in_data != r_csum);
            end
         end
`endif
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_LEN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bcnt  <= 2'd0;
         r_len   <= 32'd0;
         r_widx  <= 32'd0;
         r_bytes <= 24'd0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum  <= 8'd0;
`endif
      end else begin
         r_done <= 1'b0;
         if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         if (w_fire && ((r_state == S_LEN) || (r_state == S_DATA))) begin
            r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum + in_data;
`endif
            if (r_state == S_LEN) begin
               r_len <= w_len_full;
            end else begin
               r_bytes <= w_word[31:8];
               if (w_byte_last) begin
                  r_widx <= r_widx + 32'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_we) begin
         r_mem[r_widx[ADDR_WIDTH-1:0]] <= w_word;
      end
   end

   assign data_out      = r_mem[addr[ADDR_WIDTH+1:2]];
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;
   assign w_unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed bench for imem_loader (ADDR_WIDTH 12 and 2) against a
//            byte-stream level reference model. Honours IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       vld;
   logic [7:0]       dat;
   logic [1:0][31:0] addr;
   logic [1:0][31:0] dout;
   logic [1:0]       rdy, busy, done, err;

   imem_loader #(.ADDR_WIDTH(12)) u_big (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_data(dat), .in_ready(rdy[0]),
      .addr(addr[0]), .data_out(dout[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   imem_loader #(.ADDR_WIDTH(2)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_data(dat), .in_ready(rdy[1]),
      .addr(addr[1]), .data_out(dout[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model (stream-position arithmetic) ----------------
   int          m_depth [2];
   logic [31:0] m_mem   [2][4096];
   bit          m_known [2][4096];
   longint      m_cnt   [2];
   logic [31:0] m_len   [2];
   logic [7:0]  m_sum   [2];
   logic [31:0] m_wbuf  [2];
   bit          m_err   [2];
   bit          m_done  [2];
   bit          m_init = 1'b0;

   function automatic longint total(input int d);
      return 64'd4 + 64'd4 * longint'({32'd0, m_len[d]}) + CS;
   endfunction

   function automatic bit m_busy(input int d);
      return !(m_cnt[d] >= 4 && m_cnt[d] == total(d));
   endfunction

   task automatic m_accept(input int d, input logic [7:0] b);
      longint c = m_cnt[d];
      longint j, k;
      if (c < 4) begin
         m_len[d] = m_len[d] | ({24'd0, b} << (8 * c));
         m_sum[d] = m_sum[d] + b;
      end else if (c < 4 + 4 * longint'({32'd0, m_len[d]})) begin
         j = c - 4;
         k = j / 4;
         m_wbuf[d] = m_wbuf[d] | ({24'd0, b} << (8 * (j % 4)));
         m_sum[d]  = m_sum[d] + b;
         if (j % 4 == 3) begin
            if (k < m_depth[d]) begin
               m_mem[d][k]   = m_wbuf[d];
               m_known[d][k] = 1'b1;
            end else begin
               m_err[d] = 1'b1;
            end
            m_wbuf[d] = 32'd0;
         end
      end else begin
         if (b != m_sum[d]) m_err[d] = 1'b1;
      end
      m_cnt[d] = c + 1;
      if (!m_busy(d)) m_done[d] = 1'b1;
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_cnt[d]  = 0;
            m_len[d]  = 32'd0;
            m_sum[d]  = 8'd0;
            m_wbuf[d] = 32'd0;
            m_err[d]  = 1'b0;
            m_done[d] = 1'b0;
         end else begin
            m_done[d] = 1'b0;
            if (vld[d] && m_busy(d)) m_accept(d, dat);
         end
      end
      if (!rst_n) m_init = 1'b1;
   end

   // compare process: every cycle once the model has seen a reset
   always @(negedge clk) begin
      if (m_init) begin
         for (int d = 0; d < 2; d++) begin
            int idx;
            chk($sformatf("in_ready%0d", d), {31'd0, rdy[d]},  {31'd0, m_busy(d)});
            chk($sformatf("busy%0d", d),     {31'd0, busy[d]}, {31'd0, m_busy(d)});
            chk($sformatf("done%0d", d),     {31'd0, done[d]}, {31'd0, m_done[d]});
            chk($sformatf("err%0d", d),      {31'd0, err[d]},  {31'd0, m_err[d]});
            idx = int'((addr[d] >> 2) & (m_depth[d] - 1));
            if (m_known[d][idx]) chk($sformatf("data_out%0d", d), dout[d], m_mem[d][idx]);
         end
      end
   end

   int ndone [2];
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) if (done[d] === 1'b1) ndone[d]++;
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] ssum;

   task automatic do_reset();
      vld   = 2'b00;
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n    = 1'b1;
      ssum     = 8'd0;
      ndone[0] = 0;
      ndone[1] = 0;
   endtask

   task automatic send(input int d, input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      bit a;
      vld[d] = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      dat    = b;
      vld[d] = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         a = rdy[d];
         @(posedge clk);
         #1;
         if (a) begin ok = 1'b1; break; end
      end
      vld[d] = 1'b0;
      ssum   = ssum + b;
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout dut%0d: got in_ready 0 expected 1 within 20 cycles", d);
      end
   endtask

   task automatic send_word(input int d, input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) send(d, w[8*i +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
   endtask

   task automatic finish_stream(input int d, input logic [7:0] delta);
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] c;
      c = ssum + delta;
      send(d, c, 0);
`else
      if (delta != 8'd0) $display("note: checksum disabled, byte not sent");
`endif
   endtask

   task automatic read_chk(input int d, input logic [31:0] a, input logic [31:0] exp, input string name);
      addr[d] = a;
      @(negedge clk);
      chk(name, dout[d], exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [31:0] w3 [3];
   logic [31:0] rec [3];
   logic [31:0] sw [5];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      m_depth[0] = 4096;
      m_depth[1] = 4;
      for (int d = 0; d < 2; d++) for (int i = 0; i < 4096; i++) m_known[d][i] = 1'b0;
      w3[0] = 32'hA5A5_0001; w3[1] = 32'h1234_5678; w3[2] = 32'hCAFE_F00D;
      sw[0] = 32'h0000_1111; sw[1] = 32'h0000_2222; sw[2] = 32'h0000_3333;
      sw[3] = 32'h0000_4444; sw[4] = 32'h5555_5555;
      addr  = '0;
      dat   = 8'd0;
      vld   = 2'b00;

      // reset state
      do_reset();
      @(negedge clk);
      chk("reset_busy",  {31'd0, busy[0]}, 32'd1);
      chk("reset_done",  {31'd0, done[0]}, 32'd0);
      chk("reset_err",   {31'd0, err[0]},  32'd0);
      chk("reset_ready", {31'd0, rdy[0]},  32'd1);
      @(posedge clk); #1;

      // count=2, words 0x13 and 0xDEADBEEF
      send_word(0, 32'd2, 0);
      send_word(0, 32'h0000_0013, 0);
      send_word(0, 32'hDEAD_BEEF, 0);
      finish_stream(0, 8'd0);
      idle(2);
      read_chk(0, 32'h0, 32'h0000_0013, "t1_word0");
      read_chk(0, 32'h4, 32'hDEAD_BEEF, "t1_word1");
      read_chk(0, 32'h6, 32'hDEAD_BEEF, "t1_addr6");
      chk("t1_ndone", ndone[0], 32'd1);
      chk("t1_busy",  {31'd0, busy[0]}, 32'd0);
      chk("t1_err",   {31'd0, err[0]},  32'd0);

      // count=0: done right after the last stream byte
      do_reset();
      send_word(0, 32'd0, 0);
      finish_stream(0, 8'd0);
      @(negedge clk);
      chk("t2_done_timing", {31'd0, done[0]}, 32'd1);
      @(posedge clk); #1;
      idle(2);
      chk("t2_ndone", ndone[0], 32'd1);
      chk("t2_err",   {31'd0, err[0]}, 32'd0);
      read_chk(0, 32'h0, 32'h0000_0013, "t2_nowrite");

      // 3-word load back-to-back, scrub with zeros, then random valid gaps
      do_reset();
      send_word(0, 32'd3, 0);
      for (int i = 0; i < 3; i++) send_word(0, w3[i], 0);
      finish_stream(0, 8'd0);
      idle(1);
      for (int i = 0; i < 3; i++) begin
         addr[0] = 32'(i * 4);
         @(negedge clk);
         rec[i] = dout[0];
         @(posedge clk); #1;
      end
      do_reset();
      send_word(0, 32'd3, 0);
      for (int i = 0; i < 3; i++) send_word(0, 32'd0, 0);
      finish_stream(0, 8'd0);
      do_reset();
      send_word(0, 32'd3, 3);
      for (int i = 0; i < 3; i++) send_word(0, w3[i], 3);
      finish_stream(0, 8'd0);
      idle(1);
      chk("t3_ready_after_done", {31'd0, rdy[0]}, 32'd0);
      dat    = 8'hFF;
      vld[0] = 1'b1;
      idle(5);
      vld[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         read_chk(0, 32'(i * 4), rec[i], $sformatf("t3_same_as_b2b%0d", i));
         read_chk(0, 32'(i * 4), w3[i],  $sformatf("t3_word%0d", i));
      end
      chk("t3_ndone", ndone[0], 32'd1);
      chk("t3_err",   {31'd0, err[0]}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // wrong checksum: err set, done still pulses, data kept
      do_reset();
      send_word(0, 32'd2, 0);
      send_word(0, 32'h0BAD_0001, 0);
      send_word(0, 32'h0BAD_0002, 0);
      finish_stream(0, 8'd1);
      idle(2);
      chk("t4_err",   {31'd0, err[0]},  32'd1);
      chk("t4_ndone", ndone[0], 32'd1);
      chk("t4_busy",  {31'd0, busy[0]}, 32'd0);
      read_chk(0, 32'h0, 32'h0BAD_0001, "t4_word0");
      read_chk(0, 32'h4, 32'h0BAD_0002, "t4_word1");
`endif

      // ADDR_WIDTH=2, count=5: fifth word dropped, no wrap to word 0
      do_reset();
      send_word(1, 32'd5, 0);
      for (int i = 0; i < 4; i++) send_word(1, sw[i], 0);
      chk("t5_err_before_ovf", {31'd0, err[1]}, 32'd0);
      send_word(1, sw[4], 0);
      finish_stream(1, 8'd0);
      idle(2);
      for (int i = 0; i < 4; i++) read_chk(1, 32'(i * 4), sw[i], $sformatf("t5_word%0d", i));
      chk("t5_err",   {31'd0, err[1]}, 32'd1);
      chk("t5_ndone", ndone[1], 32'd1);

      // reset mid-load, then reload a 1-word image
      do_reset();
      send_word(0, 32'd2, 0);
      send_word(0, 32'h7777_8888, 0);
      send(0, 8'h01, 0);
      send(0, 8'h02, 0);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t6_busy_in_reset", {31'd0, busy[0]}, 32'd1);
         @(posedge clk); #1;
      end
      rst_n    = 1'b1;
      ssum     = 8'd0;
      ndone[0] = 0;
      send_word(0, 32'd1, 0);
      send_word(0, 32'h1122_3344, 0);
      finish_stream(0, 8'd0);
      idle(2);
      read_chk(0, 32'h0, 32'h1122_3344, "t6_word0");
      chk("t6_ndone", ndone[0], 32'd1);
      chk("t6_err",   {31'd0, err[0]}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream program loader. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them sequentially from word 0. It holds the core in `busy` until loading completes. Its fetch port gives the core combinational word reads, so it replaces the fixed-image instruction memory when programs are loaded at run time rather than from a hex file.

## Interface
- `ADDR_WIDTH`, default 12: word-address width; depth = 2**ADDR_WIDTH words.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `addr`  in  32  core fetch byte address; word index = `addr[ADDR_WIDTH+1:2]`, bits [1:0] and above ADDR_WIDTH+1 ignored.
- `data_out`  out  32  `mem[addr[ADDR_WIDTH+1:2]]`, combinational.
- `busy`  out  1  high while loading; core must be held in reset.
- `done`  out  1  one-cycle pulse when load completes.
- `err`  out  1  sticky error flag.

## Operation
- Stream format: 4-byte word count N (LSB first), then N words of 4 bytes each (LSB first), then, when checksum is enabled, 1 checksum byte.
- Byte transfer occurs on a rising edge with `in_valid && in_ready`. No transfer means no state change.
- States:
  - S_LEN: collect 4 count bytes into `len`. On the 4th byte, go to S_DATA if the count is nonzero. Otherwise go to S_CSUM (enabled) or S_DONE.
  - S_DATA: collect bytes in a 2-bit byte counter. On the 4th byte, write `mem[widx] <= {in_data, b2, b1, b0}` and increment `widx`. After word N, go to S_CSUM or S_DONE.
  - S_CSUM: accept 1 byte, compare, go to S_DONE.
  - S_DONE: terminal; only reset leaves it.
- `in_ready` = 1 in S_LEN/S_DATA/S_CSUM and 0 in S_DONE, decoded from state.
- Overflow: when `widx >= 2**ADDR_WIDTH`, the write is suppressed and `err` is set. Counting continues until N words are consumed, and `widx` does not wrap into low memory.
- Reset values: state S_LEN, byte counter 0, `widx` 0, `len` 0, `busy` 1, `done` 0, `err` 0, checksum accumulator 0. Memory contents are not cleared.
- Reset mid-load: the partial word is discarded, words already written stay, and the loader restarts at S_LEN.
- Fetch reads are always served. A read of the word being written in the same cycle returns the old value.

## Timing
- A written word is visible on `data_out` from the cycle after the 4th byte's edge.
- `busy` falls and `done` pulses high for exactly one cycle on the edge that enters S_DONE.
- Minimum load time: 4 + 4N (+1) cycles with `in_valid` held high.
- Back-to-back bytes are accepted every cycle, with no bubbles between count, data, and checksum.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Stream ends with one checksum byte.
  - Accumulator = 8-bit modular sum of all preceding bytes (count and data).
  - A mismatch sets `err`; `done` still pulses and `busy` still falls.
- Not defined: no S_CSUM state and no accumulator; S_DATA (or S_LEN when N=0) goes directly to S_DONE, and `err` reports overflow only.

## Test plan
- Reset, then stream count=2, words 0x00000013 and 0xDEADBEEF:
  - `data_out` at addr 0x0 = 0x00000013 and at addr 0x4 = 0xDEADBEEF.
  - addr 0x6 also returns 0xDEADBEEF.
  - `done` pulses once, `busy` = 0, `err` = 0.
- Count=0 (plus checksum 0x00 if enabled): `done` pulses 4 (5) cycles after the first byte, no memory write, `err` = 0.
- `in_valid` toggled randomly during a 3-word load: contents identical to the back-to-back load, `in_ready` = 0 after done, extra bytes ignored.
- With the checksum enabled, send a wrong checksum (correct + 1): `err` = 1, `done` pulses, memory holds the data words.
- ADDR_WIDTH=2, count=5:
  - words 0–3 written; the 5th is dropped, with word 0 unchanged.
  - `err` = 1, `done` pulses after the 5th word (or the checksum byte).
- Assert `rst_n` = 0 after 2 bytes of word 1, then reload a 1-word image 0x11223344: `busy` = 1 through reset, word 0 = 0x11223344, `done` pulses once.
